// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// spi_arb_pkg -- shared state encoding and sizing helpers for spi_cmd_arbiter
// Rev 1.0
// ============================================================================
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // The first word of a message is the address; the remaining words carry data.
  function automatic int data_w(input int reg_width, input int msg_len);
    return reg_width * (msg_len - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// spi_rr_pick -- combinational masked round-robin pick (one-hot, index, valid)
// Rev 1.0
// ============================================================================
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] src;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    masked = req_i & mask;
    // Requests at or above the pointer win; otherwise wrap to the lowest one.
    src = (|masked) ? masked : req_i;

    onehot_o = '0;
    idx_o    = '0;
    valid_o  = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (src[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// spi_cmd_arbiter -- round-robin sharing of one SPI register engine among
// NUM_REQ requesters. Optional watchdog: define SPI_ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int REG_WIDTH      = 8,
  parameter int MSG_LEN        = 2,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int DATA_W        = data_w(REG_WIDTH, MSG_LEN)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*REG_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          err,
  output logic                          busy,
  output logic                          spi_new_command,
  output logic [REG_WIDTH-1:0]          spi_addr,
  output logic [DATA_W-1:0]             spi_wdata,
  input  logic [DATA_W-1:0]             spi_rdata,
  input  logic                          spi_done,
  output logic                          spi_fault
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MSG_LEN < 2 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("spi_cmd_arbiter: parameter out of range");
  end

  arb_state_e            state_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [REG_WIDTH-1:0]  addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  cmd_q;
  logic                  busy_q;
  logic                  fault_w;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic        err_q;
  logic        fault_q;
  logic [15:0] wait_cnt_q;
  assign fault_w   = fault_q;
  assign err       = err_q;
  assign spi_fault = fault_q;
`else
  assign fault_w   = 1'b0;
  assign err       = 1'b0;
  assign spi_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cmd_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
`endif
    end else begin
      cmd_q  <= 1'b0;
      done_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_valid && !fault_w) begin
            gnt_q   <= pick_oh;
            idx_q   <= pick_idx;
            addr_q  <= req_addr[int'(pick_idx)*REG_WIDTH +: REG_WIDTH];
            wdata_q <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cmd_q   <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done) begin
            rdata_q <= spi_rdata;
            done_q  <= gnt_q;
            state_q <= ST_RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            // Fault latches until reset so a hung engine is never re-issued.
            rdata_q <= '0;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            fault_q <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          gnt_q    <= '0;
          rr_ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q  <= ST_GAP;
        end
        ST_GAP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign rdata           = rdata_q;
  assign busy            = busy_q;
  assign spi_new_command = cmd_q;
  assign spi_addr        = addr_q;
  assign spi_wdata       = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_cmd_arbiter -- directed self-checking bench for spi_cmd_arbiter
// Rev 1.0
// ============================================================================
module tb_spi_cmd_arbiter;

  localparam int RW = 8;
  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NR-1:0]  req;
  logic [NR*RW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  gnt;
  logic [NR-1:0]  done;
  logic [DW-1:0]  rdata;
  logic           err;
  logic           busy;
  logic           spi_new_command;
  logic [RW-1:0]  spi_addr;
  logic [DW-1:0]  spi_wdata;
  logic [DW-1:0]  spi_rdata;
  logic           spi_done;
  logic           spi_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(
    .REG_WIDTH      (RW),
    .MSG_LEN        (2),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req             (req),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .gnt             (gnt),
    .done            (done),
    .rdata           (rdata),
    .err             (err),
    .busy            (busy),
    .spi_new_command (spi_new_command),
    .spi_addr        (spi_addr),
    .spi_wdata       (spi_wdata),
    .spi_rdata       (spi_rdata),
    .spi_done        (spi_done),
    .spi_fault       (spi_fault)
  );

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Steps until a grant appears (bounded); returns the number of cycles taken.
  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (gnt === '0 && lat < 20);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; req_addr = '0; req_wdata = '0;
    spi_rdata = '0; spi_done = 1'b0;
    step(2);
    checks++;
    if ({gnt, done, rdata, err, busy, spi_new_command, spi_addr, spi_wdata, spi_fault} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b done=%b rdata=%h err=%b busy=%b cmd=%b addr=%h wdata=%h fault=%b, all required 0",
               gnt, done, rdata, err, busy, spi_new_command, spi_addr, spi_wdata, spi_fault);
    end
    rstn = 1'b1;
    step(2);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      failures++;
      $display("FAIL idle_no_req got busy=%b gnt=%b required 0/0000", busy, gnt);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    req_addr[2*RW +: RW]  = 8'h3A;
    req_wdata[2*DW +: DW] = 8'h5C;
    step();
    checks++;
    if (gnt !== 4'b0100 || spi_addr !== 8'h3A || spi_wdata !== 8'h5C || busy !== 1'b1 || spi_new_command !== 1'b0) begin
      failures++;
      $display("FAIL single_latch got gnt=%b addr=%h wdata=%h busy=%b cmd=%b required 0100/3a/5c/1/0",
               gnt, spi_addr, spi_wdata, busy, spi_new_command);
    end
    step();
    checks++;
    if (spi_new_command !== 1'b1) begin
      failures++;
      $display("FAIL single_cmd_high got %b required 1", spi_new_command);
    end
    req = '0;
    step();
    checks++;
    if (spi_new_command !== 1'b0 || spi_addr !== 8'h3A) begin
      failures++;
      $display("FAIL single_cmd_one_cycle got cmd=%b addr=%h required 0/3a", spi_new_command, spi_addr);
    end
    step();
    spi_done = 1'b1; spi_rdata = 8'hA5;
    step();
    spi_done = 1'b0;
    checks++;
    if (done !== 4'b0100 || rdata !== 8'hA5 || err !== 1'b0 || spi_new_command !== 1'b0) begin
      failures++;
      $display("FAIL single_done got done=%b rdata=%h err=%b cmd=%b required 0100/a5/0/0",
               done, rdata, err, spi_new_command);
    end
    step();
    checks++;
    if (done !== '0 || gnt !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_resp got done=%b gnt=%b busy=%b required 0000/0000/1", done, gnt, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_back_idle got busy=%b required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    logic [NR-1:0] exp_g;
    rstn = 1'b0; step(); rstn = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*RW +: RW]  = 8'(8'h40 + i);
      req_wdata[i*DW +: DW] = 8'(8'h80 + i);
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'(1 << (n % NR));
      wait_gnt(lat);
      checks++;
      if (lat !== ((n == 0) ? 1 : 3)) begin
        failures++;
        $display("FAIL rr_latency[%0d] got %0d cycles required %0d", n, lat, (n == 0) ? 1 : 3);
      end
      checks++;
      if (gnt !== exp_g || spi_addr !== 8'(8'h40 + n % NR)) begin
        failures++;
        $display("FAIL rr_grant[%0d] got gnt=%b addr=%h required %b/%h", n, gnt, spi_addr, exp_g, 8'(8'h40 + n % NR));
      end
      step(2);
      spi_done = 1'b1; spi_rdata = 8'(8'h10 + n);
      step();
      spi_done = 1'b0;
      if (n == 4) req = '0;
      checks++;
      if (done !== exp_g || rdata !== 8'(8'h10 + n)) begin
        failures++;
        $display("FAIL rr_done[%0d] got done=%b rdata=%h required %b/%h", n, done, rdata, exp_g, 8'(8'h10 + n));
      end
    end
    step(3);
  endtask

  task automatic test_req_drop();
    int lat;
    req_addr[1*RW +: RW]  = 8'h11; req_wdata[1*DW +: DW] = 8'h22;
    req_addr[3*RW +: RW]  = 8'h33; req_wdata[3*DW +: DW] = 8'h44;
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010 || spi_addr !== 8'h11) begin
      failures++;
      $display("FAIL drop_grant got gnt=%b addr=%h required 0010/11", gnt, spi_addr);
    end
    step();
    req = 4'b1000;
    req_addr[1*RW +: RW] = 8'h99;
    step();
    checks++;
    if (spi_addr !== 8'h11 || spi_wdata !== 8'h22 || gnt !== 4'b0010) begin
      failures++;
      $display("FAIL drop_latched got addr=%h wdata=%h gnt=%b required 11/22/0010", spi_addr, spi_wdata, gnt);
    end
    spi_done = 1'b1; spi_rdata = 8'h77;
    step();
    spi_done = 1'b0;
    checks++;
    if (done !== 4'b0010 || rdata !== 8'h77) begin
      failures++;
      $display("FAIL drop_done got done=%b rdata=%h required 0010/77", done, rdata);
    end
    wait_gnt(lat);
    checks++;
    if (lat !== 3 || gnt !== 4'b1000 || spi_addr !== 8'h33 || spi_wdata !== 8'h44) begin
      failures++;
      $display("FAIL drop_next got lat=%0d gnt=%b addr=%h wdata=%h required 3/1000/33/44", lat, gnt, spi_addr, spi_wdata);
    end
    step(2);
    spi_done = 1'b1; spi_rdata = 8'h55;
    step();
    spi_done = 1'b0;
    req = '0;
    checks++;
    if (done !== 4'b1000 || rdata !== 8'h55) begin
      failures++;
      $display("FAIL drop_next_done got done=%b rdata=%h required 1000/55", done, rdata);
    end
    step(3);
  endtask

  task automatic test_spurious_done();
    spi_done = 1'b1; spi_rdata = 8'hEE;
    step();
    spi_done = 1'b0;
    checks++;
    if (done !== '0 || busy !== 1'b0 || gnt !== '0 || rdata !== 8'h55) begin
      failures++;
      $display("FAIL spurious_done got done=%b busy=%b gnt=%b rdata=%h required 0000/0/0000/55", done, busy, gnt, rdata);
    end
    step();
    checks++;
    if (busy !== 1'b0 || spi_new_command !== 1'b0) begin
      failures++;
      $display("FAIL spurious_idle got busy=%b cmd=%b required 0/0", busy, spi_new_command);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    req_addr[2*RW +: RW] = 8'h6B;
    req = 4'b0100;
    wait_gnt(lat);
    step(2);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({gnt, done, rdata, err, busy, spi_new_command, spi_addr, spi_wdata, spi_fault} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got gnt=%b done=%b rdata=%h busy=%b cmd=%b addr=%h required all 0",
               gnt, done, rdata, busy, spi_new_command, spi_addr);
    end
    @(negedge clk);
    req = 4'b0001;
    req_addr[0*RW +: RW] = 8'hC3;
    rstn = 1'b1;
    wait_gnt(lat);
    checks++;
    if (lat !== 1 || gnt !== 4'b0001 || spi_addr !== 8'hC3) begin
      failures++;
      $display("FAIL reset_mid_regrant got lat=%0d gnt=%b addr=%h required 1/0001/c3", lat, gnt, spi_addr);
    end
    step(2);
    spi_done = 1'b1; spi_rdata = 8'h3C;
    step();
    spi_done = 1'b0;
    req = '0;
    checks++;
    if (done !== 4'b0001 || rdata !== 8'h3C) begin
      failures++;
      $display("FAIL reset_mid_done got done=%b rdata=%h required 0001/3c", done, rdata);
    end
    step(3);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    int stray;
    req = 4'b0010;
    wait_gnt(lat);
    req = '0;
    step(16);
    checks++;
    if (done !== '0) begin
      failures++;
      $display("FAIL timeout_early got done=%b required 0000", done);
    end
    step();
    checks++;
    if (done !== 4'b0010 || err !== 1'b1 || rdata !== '0 || spi_fault !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fire got done=%b err=%b rdata=%h fault=%b required 0010/1/00/1", done, err, rdata, spi_fault);
    end
    req = 4'b1111;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (gnt !== '0 || spi_new_command !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0 || spi_fault !== 1'b1) begin
      failures++;
      $display("FAIL timeout_blocked got stray_cycles=%0d fault=%b required 0/1", stray, spi_fault);
    end
    req = '0;
  endtask
`else
  task automatic test_no_timeout();
    int lat;
    req = 4'b0010;
    wait_gnt(lat);
    req = '0;
    step(40);
    checks++;
    if (busy !== 1'b1 || done !== '0 || gnt !== 4'b0010 || err !== 1'b0 || spi_fault !== 1'b0) begin
      failures++;
      $display("FAIL wait_forever got busy=%b done=%b gnt=%b err=%b fault=%b required 1/0000/0010/0/0",
               busy, done, gnt, err, spi_fault);
    end
    spi_done = 1'b1; spi_rdata = 8'h99;
    step();
    spi_done = 1'b0;
    checks++;
    if (done !== 4'b0010 || rdata !== 8'h99 || err !== 1'b0) begin
      failures++;
      $display("FAIL late_done got done=%b rdata=%h err=%b required 0010/99/0", done, rdata, err);
    end
    step(3);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_req_drop();
    test_spurious_done();
    test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
